// File: rtl/bus_decoder_ws.sv
// bus_decoder_ws: registered memory-map decoder with per-region wait states; ROM-write error path under DECODE_ERR_EN.
module bus_decoder_ws #(
  parameter int ADDR_W = 20,
  parameter int RAM_CHIPS = 4,
  parameter logic [ADDR_W-1:0] ROM_TOP = 20'h04000,
  parameter logic [ADDR_W-1:0] VR_BASE = 20'hF0000,
  parameter int unsigned ROM_WS = 2,
  parameter int unsigned RAM_WS = 0,
  parameter int unsigned VR_WS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  output logic [ADDR_W-1:0]    addr_q,
  output logic                 we_q,
  output logic                 cs_rom,
  output logic                 cs_vr,
  output logic [RAM_CHIPS-1:0] cs_ram,
  output logic                 busy,
  output logic                 ready,
  output logic                 err
);
  localparam int BW = $clog2(RAM_CHIPS);
`ifdef DECODE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [3:0] cnt, ws;
  logic is_rom, is_vr, rom_wr;
  logic [RAM_CHIPS-1:0] bank_sel;
  always_comb begin
    is_rom = addr < ROM_TOP;
    is_vr = !is_rom && addr >= VR_BASE;
    rom_wr = ERR_EN && is_rom && we;
    ws = rom_wr ? 4'd0 : is_rom ? 4'(ROM_WS) : is_vr ? 4'(VR_WS) : 4'(RAM_WS);
    bank_sel = (is_rom || is_vr) ? '0 : RAM_CHIPS'(1) << addr[ADDR_W-1 -: BW];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      we_q <= 1'b0;
      cs_rom <= 1'b0;
      cs_vr <= 1'b0;
      cs_ram <= '0;
      busy <= 1'b0;
      ready <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q <= addr;
          we_q <= we;
          cs_rom <= is_rom && !rom_wr;
          cs_vr <= is_vr;
          cs_ram <= bank_sel;
          busy <= 1'b1;
          cnt <= ws;
          err <= rom_wr;
          ready <= !rom_wr && ws == 4'd0;
          state <= ws != 4'd0 ? WAIT : ACK;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACK;
            ready <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          cs_rom <= 1'b0;
          cs_vr <= 1'b0;
          cs_ram <= '0;
          busy <= 1'b0;
          ready <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_decoder_ws.sv
// tb_bus_decoder_ws: scoreboard bench for bus_decoder_ws with default parameters.
module tb_bus_decoder_ws;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [19:0] addr = '0, addr_q;
  logic we_q, cs_rom, cs_vr, busy, ready, err;
  logic [3:0] cs_ram;
  int checks = 0, errors = 0;
  logic mon_en = 1'b0;
  typedef struct {
    logic [19:0] a;
    logic w, rom, vr;
    logic [3:0] ram;
    int len, rdy_at;
    logic e;
  } exp_t;
  exp_t sb[$];

  bus_decoder_ws dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .addr_q(addr_q), .we_q(we_q), .cs_rom(cs_rom), .cs_vr(cs_vr),
    .cs_ram(cs_ram), .busy(busy), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [19:0] a, input logic w, input logic rom, input logic vr,
                              input logic [3:0] ram, input int len, input int rdy_at, input logic e);
    exp_t x;
    x.a = a; x.w = w; x.rom = rom; x.vr = vr; x.ram = ram;
    x.len = len; x.rdy_at = rdy_at; x.e = e;
    return x;
  endfunction

  // monitor: pop one expectation per busy burst, check every cycle of it
  initial begin
    exp_t cur;
    int k = 0;
    logic prev_busy = 1'b0;
    cur = mk('0, 1'b0, 1'b0, 1'b0, 4'd0, 0, -1, 1'b0);
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy) begin
          if (!prev_busy) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) cur = sb.pop_front();
            k = 0;
          end
          chk("cs_rom", 32'(cs_rom), 32'(cur.rom));
          chk("cs_vr", 32'(cs_vr), 32'(cur.vr));
          chk("cs_ram", 32'(cs_ram), 32'(cur.ram));
          chk("ready", 32'(ready), 32'(k == cur.rdy_at));
          chk("err", 32'(err), 32'(cur.e && k == 0));
          if (k == 0) begin
            chk("addr_q", 32'(addr_q), 32'(cur.a));
            chk("we_q", 32'(we_q), 32'(cur.w));
          end
          k++;
        end else begin
          if (prev_busy) chk("busy_len", 32'(k), 32'(cur.len));
          chk("idle_outs", 32'({cs_rom, cs_vr, cs_ram, ready, err}), 32'd0);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; busy && n < 40; n++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic access(input logic [19:0] a, input logic w, input exp_t e);
    sb.push_back(e);
    req = 1'b1; addr = a; we = w;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_outs", 32'({cs_rom, cs_vr, cs_ram, busy, ready, err, we_q}), 32'd0);
      chk("rst_addr_q", 32'(addr_q), 32'd0);
    end
    mon_en = 1'b1;
    access(20'h00100, 1'b0, mk(20'h00100, 1'b0, 1'b1, 1'b0, 4'b0000, 3, 2, 1'b0));
    access(20'h80000, 1'b0, mk(20'h80000, 1'b0, 1'b0, 1'b0, 4'b0100, 1, 0, 1'b0));
    access(20'h04000, 1'b1, mk(20'h04000, 1'b1, 1'b0, 1'b0, 4'b0001, 1, 0, 1'b0));
    access(20'hEFFFF, 1'b0, mk(20'hEFFFF, 1'b0, 1'b0, 1'b0, 4'b1000, 1, 0, 1'b0));
    access(20'h03FFF, 1'b0, mk(20'h03FFF, 1'b0, 1'b1, 1'b0, 4'b0000, 3, 2, 1'b0));
    access(20'hFFFFF, 1'b1, mk(20'hFFFFF, 1'b1, 1'b0, 1'b1, 4'b0000, 2, 1, 1'b0));
    // req held through a VR access with addr changed: next ROM access only after an idle cycle
    sb.push_back(mk(20'hF0000, 1'b0, 1'b0, 1'b1, 4'b0000, 2, 1, 1'b0));
    sb.push_back(mk(20'h00000, 1'b0, 1'b1, 1'b0, 4'b0000, 3, 2, 1'b0));
    req = 1'b1; addr = 20'hF0000; we = 1'b0;
    @(negedge clk);
    addr = 20'h00000;
    wait_idle();
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    // reset during cycle E0+2 of a ROM access: no ready, two busy cycles
    sb.push_back(mk(20'h00200, 1'b0, 1'b1, 1'b0, 4'b0000, 2, -1, 1'b0));
    req = 1'b1; addr = 20'h00200;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
`ifdef DECODE_ERR_EN
    access(20'h00010, 1'b1, mk(20'h00010, 1'b1, 1'b0, 1'b0, 4'b0000, 1, -1, 1'b1));
`else
    access(20'h00010, 1'b1, mk(20'h00010, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 2, 1'b0));
`endif
    access(20'h40000, 1'b0, mk(20'h40000, 1'b0, 1'b0, 1'b0, 4'b0010, 1, 0, 1'b0));
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
